// File: rtl/packet_tx_pkg.sv
// Shared constants, FSM state type and CRC-32 helper
// for the byte-wide Ethernet transmit path.
package packet_tx_pkg;

  localparam logic [1:0]  CTL_IDLE      = 2'b00;
  localparam logic [1:0]  CTL_DATA      = 2'b11;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam int          PREAMBLE_LEN  = 7;
  localparam int          FCS_LEN       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_e;

  // Reflected CRC-32: fold the byte in, then shift out 8 bits.
  function automatic logic [31:0] crc32_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ (r[0] ? CRC32_POLY : 32'h0);
    end
    return r;
  endfunction

endpackage

// File: rtl/dpram.sv
// Simple dual-port RAM, one write port and one
// synchronous read port, both on the same clock.
module dpram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  // Storage is never reset; read data is one cycle late.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/packet_tx_crc32_d8.sv
// Byte-parallel CRC-32 accumulator, reusable on the
// receive side for FCS checking.
module crc32_d8
  import packet_tx_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;

  // Clear wins over update; one byte folded per enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_crc <= CRC32_INIT;
    end else if (i_clr) begin
      r_crc <= CRC32_INIT;
    end else if (i_en) begin
      r_crc <= crc32_byte(r_crc, i_data);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/packet_tx.sv
// Ethernet frame transmitter: preamble, SFD, buffered
// payload, zero pad, FCS and inter-frame gap.
module packet_tx
  import packet_tx_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int MIN_PAYLOAD = 60,
  parameter int IFG_CYCLES  = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [7:0]           wr_data,
  input  logic                 start,
  input  logic [ADDR_BITS:0]   len,
  output logic                 busy,
  output logic [7:0]           data,
  output logic [1:0]           ctl,
  output logic [7:0]           packet_count_tx
);

  typedef logic [ADDR_BITS:0]   len_t;
  typedef logic [ADDR_BITS-1:0] addr_t;

  localparam len_t LP_MAX_LEN  = len_t'(2**ADDR_BITS);
  localparam len_t LP_MIN      = len_t'(MIN_PAYLOAD);
  localparam len_t LP_PRE_LAST = len_t'(PREAMBLE_LEN - 1);
  localparam len_t LP_FCS_LAST = len_t'(FCS_LEN - 1);
  localparam len_t LP_IFG_LAST = len_t'(IFG_CYCLES - 1);

  tx_state_e   r_state;
  len_t        r_cnt;
  len_t        r_len;
  addr_t       r_ptr;
  logic [7:0]  r_data;
  logic [1:0]  r_ctl;
  logic        r_busy;
  logic [7:0]  r_pkt_cnt;

  logic        w_accept;
  len_t        w_len;
  logic        w_last_pay;
  logic        w_last_pad;
  logic        w_short;
  logic [7:0]  w_rd_data;
  logic [31:0] w_crc;
  logic [31:0] w_fcs;
  logic [7:0]  w_fcs_next;
  logic        w_crc_en;
  logic [7:0]  w_crc_data;

  assign w_accept   = (r_state == ST_IDLE) && start
                      && (len != '0);
  assign w_len      = (len > LP_MAX_LEN) ? LP_MAX_LEN : len;
  assign w_last_pay = (r_cnt == r_len - len_t'(1));
  assign w_last_pad = (r_cnt == LP_MIN - len_t'(1));
  assign w_short    = (r_len < LP_MIN);
  assign w_fcs      = ~w_crc;
  assign w_fcs_next = 8'(w_fcs >> {r_cnt[1:0] + 2'd1, 3'b000});

  dpram #(
    .AW (ADDR_BITS),
    .DW (8)
  ) u_buf (
    .clk     (clk),
    .i_we    (wr_en),
    .i_waddr (wr_addr),
    .i_wdata (wr_data),
    .i_raddr (r_ptr),
    .o_rdata (w_rd_data)
  );

  // Fold each payload/pad byte as it is loaded into the output register.
  always_comb begin
    w_crc_en   = 1'b0;
    w_crc_data = 8'h00;
    if (r_state == ST_SFD) begin
      w_crc_en   = 1'b1;
      w_crc_data = w_rd_data;
    end else if (r_state == ST_PAYLOAD) begin
      if (!w_last_pay) begin
        w_crc_en   = 1'b1;
        w_crc_data = w_rd_data;
      end else if (w_short) begin
        w_crc_en = 1'b1;
      end
    end else if (r_state == ST_PAD) begin
      w_crc_en = !w_last_pad;
    end
  end

  crc32_d8 u_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_accept),
    .i_en    (w_crc_en),
    .i_data  (w_crc_data),
    .o_crc   (w_crc)
  );

  // Frame sequencer; r_ptr runs two bytes ahead of the output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_len     <= '0;
      r_ptr     <= '0;
      r_data    <= 8'h00;
      r_ctl     <= CTL_IDLE;
      r_busy    <= 1'b0;
      r_pkt_cnt <= 8'h00;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_PREAMBLE;
            r_cnt   <= '0;
            r_len   <= w_len;
            r_ptr   <= '0;
            r_data  <= PREAMBLE_BYTE;
            r_ctl   <= CTL_DATA;
            r_busy  <= 1'b1;
          end
        end
        ST_PREAMBLE: begin
          if (r_cnt == LP_PRE_LAST) begin
            r_state <= ST_SFD;
            r_cnt   <= '0;
            r_data  <= SFD_BYTE;
            r_ptr   <= r_ptr + addr_t'(1);
          end else begin
            r_cnt <= r_cnt + len_t'(1);
          end
        end
        ST_SFD: begin
          r_state <= ST_PAYLOAD;
          r_data  <= w_rd_data;
          r_ptr   <= r_ptr + addr_t'(1);
        end
        ST_PAYLOAD: begin
          if (!w_last_pay) begin
            r_data <= w_rd_data;
            r_ptr  <= r_ptr + addr_t'(1);
            r_cnt  <= r_cnt + len_t'(1);
          end else if (w_short) begin
            r_state <= ST_PAD;
            r_data  <= 8'h00;
            r_cnt   <= r_cnt + len_t'(1);
          end else begin
            r_state <= ST_FCS;
            r_data  <= w_fcs[7:0];
            r_cnt   <= '0;
          end
        end
        ST_PAD: begin
          if (w_last_pad) begin
            r_state <= ST_FCS;
            r_data  <= w_fcs[7:0];
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + len_t'(1);
          end
        end
        ST_FCS: begin
          if (r_cnt == LP_FCS_LAST) begin
            r_state   <= ST_IFG;
            r_cnt     <= '0;
            r_data    <= 8'h00;
            r_ctl     <= CTL_IDLE;
            r_pkt_cnt <= r_pkt_cnt + 8'd1;
          end else begin
            r_data <= w_fcs_next;
            r_cnt  <= r_cnt + len_t'(1);
          end
        end
        ST_IFG: begin
          if (r_cnt == LP_IFG_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + len_t'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy            = r_busy;
  assign data            = r_data;
  assign ctl             = r_ctl;
  assign packet_count_tx = r_pkt_cnt;

endmodule

// File: tb/tb_packet_tx.sv
// Directed bench for packet_tx with a byte scoreboard
// and a receiver model checking length, gap and FCS.
module tb_packet_tx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       start = 1'b0;
  logic [8:0] len = 9'h000;
  logic       busy;
  logic [7:0] data;
  logic [1:0] ctl;
  logic [7:0] packet_count_tx;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  int         exp_len[$];
  logic [7:0] mdl[256];
  bit         chk_gap = 1'b0;

  int         run = 0;
  int         gap = 0;
  int         ifg = 0;
  bit         in_ifg = 1'b0;
  logic [7:0] rx[$];

  packet_tx #(
    .ADDR_BITS   (8),
    .MIN_PAYLOAD (60),
    .IFG_CYCLES  (12)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .start           (start),
    .len             (len),
    .busy            (busy),
    .data            (data),
    .ctl             (ctl),
    .packet_count_tx (packet_count_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference CRC, LSB of each byte first.
  function automatic logic [31:0] crc_bits(input logic [31:0] c,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = {1'b0, r[31:1]} ^ 32'hEDB88320;
      else             r = {1'b0, r[31:1]};
    end
    return r;
  endfunction

  task automatic push_frame(input int l);
    logic [31:0] c;
    logic [7:0]  b;
    int          n;
    c = 32'hFFFF_FFFF;
    n = (l < 60) ? 60 : l;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int k = 0; k < n; k++) begin
      b = (k < l) ? mdl[k] : 8'h00;
      exp_q.push_back(b);
      c = crc_bits(c, b);
    end
    c = ~c;
    for (int j = 0; j < 4; j++) exp_q.push_back(c[8*j +: 8]);
    exp_len.push_back(n + 12);
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a[7:0];
    wr_data = d;
    mdl[a]  = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic send(input int l, input bit expect_frame);
    @(negedge clk);
    start = 1'b1;
    len   = 9'(l);
    if (expect_frame) push_frame(l);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_ctl(input logic [1:0] v, input int budget,
                          input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ctl === v) break;
    end
    chk(tag, {30'b0, ctl}, {30'b0, v});
  endtask

  // Receiver model: scoreboard bytes, frame length, IFG, gap, residue.
  always @(negedge clk) begin
    logic [31:0] c;
    if (!reset_n) begin
      run    = 0;
      gap    = 0;
      ifg    = 0;
      in_ifg = 1'b0;
      rx.delete();
    end else if (ctl === 2'b11) begin
      if (run == 0 && chk_gap) chk("frame_gap", gap, 13);
      run++;
      chk("busy_in_frame", {31'b0, busy}, 32'd1);
      if (exp_q.size() == 0) begin
        chk("extra_byte", {24'b0, data}, 32'hFFFF_FFFF);
      end else begin
        chk("tx_byte", {24'b0, data}, {24'b0, exp_q.pop_front()});
      end
      rx.push_back(data);
    end else begin
      chk("idle_code", {22'b0, ctl, data}, 32'd0);
      if (run != 0) begin
        if (exp_len.size() == 0) chk("frame_len", run, -1);
        else chk("frame_len", run, exp_len.pop_front());
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < rx.size(); i++) c = crc_bits(c, rx[i]);
        chk("fcs_residue", c, 32'hDEBB_20E3);
        rx.delete();
        run    = 0;
        gap    = 0;
        ifg    = 0;
        in_ifg = 1'b1;
      end
      gap++;
      if (in_ifg) begin
        if (busy) begin
          ifg++;
        end else begin
          chk("ifg_len", ifg, 12);
          in_ifg = 1'b0;
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ctl", {30'b0, ctl}, 32'd0);
    chk("rst_data", {24'b0, data}, 32'd0);
    chk("rst_count", {24'b0, packet_count_tx}, 32'd0);
    #2 reset_n = 1'b1;

    wr(0, 8'hAB);
    send(1, 1'b1);
    chk("lat_busy", {31'b0, busy}, 32'd1);
    chk("lat_ctl", {30'b0, ctl}, 32'd3);
    chk("lat_data", {24'b0, data}, 32'h55);
    wait_idle(400);
    chk("count_len1", {24'b0, packet_count_tx}, 32'd1);
    chk("q_len1", exp_q.size(), 0);

    for (int a = 0; a < 60; a++) wr(a, 8'(a));
    send(60, 1'b1);
    wait_idle(400);
    chk("count_len60", {24'b0, packet_count_tx}, 32'd2);
    chk("q_len60", exp_q.size(), 0);

    for (int a = 0; a < 256; a++) wr(a, 8'($urandom));
    send(256, 1'b1);
    wait_idle(600);
    chk("count_len256", {24'b0, packet_count_tx}, 32'd3);
    chk("q_len256", exp_q.size(), 0);

    send(0, 1'b0);
    repeat (3) @(negedge clk);
    chk("len0_busy", {31'b0, busy}, 32'd0);
    chk("len0_ctl", {30'b0, ctl}, 32'd0);
    send(5, 1'b1);
    repeat (10) @(negedge clk);
    send(10, 1'b0);
    wait_idle(400);
    chk("count_ignored", {24'b0, packet_count_tx}, 32'd4);
    chk("q_ignored", exp_q.size(), 0);
    chk("len_q_ignored", exp_len.size(), 0);

    for (int a = 0; a < 60; a++) wr(a, 8'hF0 ^ 8'(a));
    send(60, 1'b1);
    repeat (20) @(negedge clk);
    chk("pre_rst_ctl", {30'b0, ctl}, 32'd3);
    #2 reset_n = 1'b0;
    exp_q.delete();
    exp_len.delete();
    #1;
    chk("arst_ctl", {30'b0, ctl}, 32'd0);
    chk("arst_data", {24'b0, data}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_count", {24'b0, packet_count_tx}, 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    send(20, 1'b1);
    wait_idle(400);
    chk("count_after_rst", {24'b0, packet_count_tx}, 32'd1);
    chk("q_after_rst", exp_q.size(), 0);

    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("rst2_count", {24'b0, packet_count_tx}, 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 256; i++) push_frame(4);
    @(negedge clk);
    start = 1'b1;
    len   = 9'd4;
    for (int i = 0; i < 256; i++) begin
      wait_ctl(2'b11, 100, "held_start");
      if (i == 0) begin
        @(negedge clk);
        chk_gap = 1'b1;
      end
      if (i == 255) start = 1'b0;
      wait_ctl(2'b00, 200, "held_end");
    end
    wait_idle(100);
    chk_gap = 1'b0;
    chk("count_wrap", {24'b0, packet_count_tx}, 32'd0);
    chk("q_held", exp_q.size(), 0);
    chk("len_q_held", exp_len.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
